// File: rtl/dataflow_sequencer_if.sv
// Program-in / response-out stream bundle for dataflow_sequencer.
// Both channels use valid/ready: a beat transfers on a rising clock edge where valid && ready; the producer holds its payload stable until then.
interface dataflow_sequencer_if #(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 4
) ();
  localparam int INSTR_W = 2*DATA_W + 5;
  localparam int CNT_W   = $clog2(NUM_PE + 1);

  logic [INSTR_W-1:0] in_instr;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_fault;
  logic [CNT_W-1:0]   out_count;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_instr, in_valid, out_ready,
    output in_ready, out_data, out_fault, out_count, out_valid
  );

  modport master (
    output in_instr, in_valid, out_ready,
    input  in_ready, out_data, out_fault, out_count, out_valid
  );
endinterface

// File: rtl/dataflow_sequencer.sv
// Loads a short program of PE instructions (one per slot), evaluates the slots
// in order through a small ALU and returns the last slot's result or a fault.
module dataflow_sequencer #(
  parameter int NUM_PE  = 4,
  parameter int DATA_W  = 4,
  parameter int INSTR_W = 2*DATA_W + 5
) (
  input  logic                 clock,
  input  logic                 reset,
  dataflow_sequencer_if.slave  bus,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam int CMP_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic               fault_q, fault_d;

  logic [DATA_W-1:0]  src0_q   [NUM_PE];
  logic [DATA_W-1:0]  src1_q   [NUM_PE];
  logic               imm0_q   [NUM_PE];
  logic               imm1_q   [NUM_PE];
  logic [1:0]         op_q     [NUM_PE];
  logic [DATA_W-1:0]  result_q [NUM_PE];

  logic               in_last;
  logic [DATA_W-1:0]  in_src0, in_src1;
  logic               in_imm0, in_imm1;
  logic [1:0]         in_op;

  logic               store_en, exec_en, ref_fault, prog_end;
  logic [IDX_W-1:0]   load_idx, last_idx;
  logic [DATA_W-1:0]  op_a, op_b, alu_y;

  assign {in_last, in_src0, in_src1, in_imm0, in_imm1, in_op} = bus.in_instr[INSTR_W-1:0];

  assign load_idx    = load_cnt_q[IDX_W-1:0];
  assign last_idx    = IDX_W'(load_cnt_q - 1'b1);
  assign dbg_state_o = state_q;

  // A register reference must point at an already-loaded slot. Any src at or
  // above load_cnt is illegal, which also covers src bits above the index field.
  function automatic logic bad_ref(input logic [DATA_W-1:0] src, input logic use_imm,
                                   input logic [CNT_W-1:0] cnt);
    return !use_imm && (CMP_W'(src) >= CMP_W'(cnt));
  endfunction

  assign ref_fault = bad_ref(in_src0, in_imm0, load_cnt_q) || bad_ref(in_src1, in_imm1, load_cnt_q);
  assign prog_end  = in_last || (load_cnt_q == CNT_W'(NUM_PE - 1));

  always_comb begin
    op_a = imm0_q[exec_cnt_q] ? src0_q[exec_cnt_q] : result_q[src0_q[exec_cnt_q][IDX_W-1:0]];
    op_b = imm1_q[exec_cnt_q] ? src1_q[exec_cnt_q] : result_q[src1_q[exec_cnt_q][IDX_W-1:0]];
    case (op_q[exec_cnt_q])
      2'b00:   alu_y = op_a + op_b;
      2'b01:   alu_y = op_a - op_b;
      2'b10:   alu_y = op_a & op_b;
      default: alu_y = op_a ^ op_b;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    exec_cnt_d    = exec_cnt_q;
    fault_d       = fault_q;
    store_en      = 1'b0;
    exec_en       = 1'b0;
    busy          = 1'b1;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_fault = 1'b0;
    bus.out_count = '0;
    case (state_q)
      LOAD: begin
        busy         = 1'b0;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          store_en   = 1'b1;
          load_cnt_d = load_cnt_q + 1'b1;
          fault_d    = ref_fault;
          if (prog_end)       state_d = ref_fault ? RESP : EXEC;
          else if (ref_fault) state_d = DRAIN;
        end
      end
      // Swallow the rest of a faulted program so the next one starts clean.
      DRAIN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (prog_end) state_d = RESP;
        end
      end
      EXEC: begin
        exec_en    = 1'b1;
        exec_cnt_d = exec_cnt_q + 1'b1;
        if (exec_cnt_q == last_idx) state_d = RESP;
      end
      RESP: begin
        bus.out_valid = 1'b1;
        bus.out_data  = fault_q ? '0 : result_q[last_idx];
        bus.out_fault = fault_q;
        bus.out_count = load_cnt_q;
        if (bus.out_ready) begin
          load_cnt_d = '0;
          exec_cnt_d = '0;
          fault_d    = 1'b0;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      exec_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      exec_cnt_q <= exec_cnt_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) begin
        src0_q[i]   <= '0;
        src1_q[i]   <= '0;
        imm0_q[i]   <= 1'b0;
        imm1_q[i]   <= 1'b0;
        op_q[i]     <= '0;
        result_q[i] <= '0;
      end
    end else begin
      if (store_en) begin
        src0_q[load_idx] <= in_src0;
        src1_q[load_idx] <= in_src1;
        imm0_q[load_idx] <= in_imm0;
        imm1_q[load_idx] <= in_imm1;
        op_q[load_idx]   <= in_op;
      end
      if (exec_en) result_q[exec_cnt_q] <= alu_y;
    end
  end
endmodule

// File: tb/tb_dataflow_sequencer.sv
// Self-checking bench for dataflow_sequencer: directed programs plus random
// programs scored against a slot-by-slot arithmetic model.
module tb_dataflow_sequencer;
  localparam int NUM_PE = 4;
  localparam int DATA_W = 4;
  localparam int IDX    = 2;
  localparam int IW     = 2*DATA_W + 5;

  typedef struct {
    logic              last;
    logic [DATA_W-1:0] s0, s1;
    logic              i0, i1;
    logic [1:0]        op;
  } ins_t;

  // clock / reset
  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  dataflow_sequencer_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) bus ();
  dataflow_sequencer_if #(.NUM_PE(8), .DATA_W(8)) bus8 ();
  logic       busy, busy8;
  logic [1:0] dbg, dbg8;

  dataflow_sequencer #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) u_dut (
    .clock(clock), .reset(rst_n), .bus(bus), .busy(busy), .dbg_state_o(dbg));
  dataflow_sequencer #(.NUM_PE(8), .DATA_W(8)) u_dut8 (
    .clock(clock), .reset(rst_n), .bus(bus8), .busy(busy8), .dbg_state_o(dbg8));

  int n_cmp = 0;
  int n_bad = 0;

  ins_t              prog_q[$];
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] obs_data;
  logic obs_fault, obs_valid, obs_stable, obs_rdy, obs_rdy_after, obs_valid_after, obs_to;
  int   obs_count, obs_lat;

  // reference model
  function automatic void add(input logic last, input int s0, input int s1,
                              input logic i0, input logic i1, input int op);
    ins_t x;
    x.last = last; x.s0 = DATA_W'(s0); x.s1 = DATA_W'(s1);
    x.i0 = i0; x.i1 = i1; x.op = 2'(op);
    prog_q.push_back(x);
  endfunction

  function automatic logic [IW-1:0] enc(input ins_t x);
    return {x.last, x.s0, x.s1, x.i0, x.i1, x.op};
  endfunction

  function automatic logic ref_bad(input logic [DATA_W-1:0] s, input logic imm, input int k);
    int v;
    v = int'(s);
    return !imm && (((v >> IDX) != 0) || ((v & ((1 << IDX) - 1)) >= k));
  endfunction

  function automatic int alu(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    return r & ((1 << DATA_W) - 1);
  endfunction

  function automatic void model(output logic [DATA_W-1:0] d, output logic f,
                                output int cnt, output int lat);
    int res[NUM_PE];
    int a, b;
    f = 1'b0;
    cnt = prog_q.size();
    foreach (prog_q[k]) begin
      if (ref_bad(prog_q[k].s0, prog_q[k].i0, k) || ref_bad(prog_q[k].s1, prog_q[k].i1, k)) f = 1'b1;
      if (!f) begin
        a = prog_q[k].i0 ? int'(prog_q[k].s0) : res[int'(prog_q[k].s0)];
        b = prog_q[k].i1 ? int'(prog_q[k].s1) : res[int'(prog_q[k].s1)];
        res[k] = alu(prog_q[k].op, a, b);
      end
    end
    d   = f ? '0 : DATA_W'(res[cnt-1]);
    lat = f ? 1 : cnt + 1;
  endfunction

  // driver tasks
  task automatic send_prog();
    int g;
    obs_to = 1'b0;
    foreach (prog_q[k]) begin
      bus.in_instr = enc(prog_q[k]);
      bus.in_valid = 1'b1;
      g = 0;
      while (!bus.in_ready && g < 50) begin @(negedge clock); g++; end
      if (!bus.in_ready) obs_to = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect_resp(input int hold, input logic early);
    obs_lat = 1;
    while (!bus.out_valid && obs_lat < 200) begin @(negedge clock); obs_lat++; end
    obs_valid  = bus.out_valid;
    obs_data   = bus.out_data;
    obs_fault  = bus.out_fault;
    obs_count  = int'(bus.out_count);
    obs_rdy    = bus.in_ready;
    obs_stable = 1'b1;
    if (!early) begin
      repeat (hold) begin
        @(negedge clock);
        if (!bus.out_valid || bus.in_ready || bus.out_data !== obs_data ||
            bus.out_fault !== obs_fault || int'(bus.out_count) != obs_count) obs_stable = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready   = 1'b0;
    obs_rdy_after   = bus.in_ready;
    obs_valid_after = bus.out_valid;
  endtask

  task automatic load_test1();
    prog_q.delete();
    add(0, 3, 5, 1, 1, 0);
    add(0, 0, 1, 0, 1, 1);
    add(0, 1, 0, 0, 0, 3);
    add(1, 2, 6, 0, 1, 2);
  endtask

  // scenarios
  task automatic test_reset();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0 || bus.out_fault !== 1'b0 || bus.out_count !== '0)
      begin n_bad++; $display("FAIL reset_outputs got data=%0d fault=%b count=%0d want 0/0/0", bus.out_data, bus.out_fault, bus.out_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL post_reset_idle got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_basic();
    load_test1();
    send_prog();
    collect_resp(0, 1'b0);
    n_cmp++; if (obs_data !== 4'd6) begin n_bad++; $display("FAIL basic_data got %0d want 6", obs_data); end
    n_cmp++; if (obs_fault !== 1'b0) begin n_bad++; $display("FAIL basic_fault got %b want 0", obs_fault); end
    n_cmp++; if (obs_count != 4) begin n_bad++; $display("FAIL basic_count got %0d want 4", obs_count); end
    n_cmp++; if (obs_lat != 5 || obs_to) begin n_bad++; $display("FAIL basic_latency got %0d (stall=%b) want 5", obs_lat, obs_to); end
    n_cmp++; if (obs_rdy_after !== 1'b1 || obs_valid_after !== 1'b0)
      begin n_bad++; $display("FAIL basic_after_hs got in_ready=%b out_valid=%b want 1/0", obs_rdy_after, obs_valid_after); end
  endtask

  task automatic test_wrap();
    prog_q.delete();
    add(1, 15, 2, 1, 1, 0);
    send_prog();
    collect_resp(0, 1'b0);
    n_cmp++; if (obs_data !== 4'd1) begin n_bad++; $display("FAIL wrap_data got %0d want 1", obs_data); end
    n_cmp++; if (obs_count != 1 || obs_lat != 2)
      begin n_bad++; $display("FAIL wrap_count_lat got count=%0d lat=%0d want 1/2", obs_count, obs_lat); end
  endtask

  task automatic test_self_ref();
    prog_q.delete();
    add(0, 4, 4, 1, 1, 0);
    add(0, 1, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3);
    add(1, 1, 1, 1, 1, 2);
    send_prog();
    collect_resp(0, 1'b0);
    n_cmp++; if (obs_fault !== 1'b1 || obs_data !== '0)
      begin n_bad++; $display("FAIL selfref_fault got fault=%b data=%0d want 1/0", obs_fault, obs_data); end
    n_cmp++; if (obs_count != 4 || obs_lat != 1 || obs_to)
      begin n_bad++; $display("FAIL selfref_count_lat got count=%0d lat=%0d want 4/1", obs_count, obs_lat); end
  endtask

  task automatic test_implicit_end_hold();
    logic [DATA_W-1:0] ed; logic ef; int ec, el;
    prog_q.delete();
    add(0, $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, $urandom_range(0, 3));
    add(0, 0, $urandom_range(0, 15), 0, 1, $urandom_range(0, 3));
    add(0, 1, 0, 0, 0, $urandom_range(0, 3));
    add(0, 2, $urandom_range(0, 15), 0, 1, $urandom_range(0, 3));
    model(ed, ef, ec, el);
    send_prog();
    collect_resp(3, 1'b0);
    n_cmp++; if (obs_data !== ed || obs_fault !== ef)
      begin n_bad++; $display("FAIL implicit_data got %0d/%b want %0d/%b", obs_data, obs_fault, ed, ef); end
    n_cmp++; if (obs_count != ec || obs_lat != el)
      begin n_bad++; $display("FAIL implicit_count_lat got %0d/%0d want %0d/%0d", obs_count, obs_lat, ec, el); end
    n_cmp++; if (obs_stable !== 1'b1 || obs_rdy !== 1'b0)
      begin n_bad++; $display("FAIL hold_stable got stable=%b in_ready=%b want 1/0", obs_stable, obs_rdy); end
  endtask

  task automatic test_reset_mid();
    load_test1();
    send_prog();
    @(negedge clock);
    n_cmp++; if (busy !== 1'b1 || bus.in_ready !== 1'b0)
      begin n_bad++; $display("FAIL exec_busy got busy=%b in_ready=%b want 1/0", busy, bus.in_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_count !== '0)
      begin n_bad++; $display("FAIL midreset_outputs got valid=%b ready=%b busy=%b count=%0d want 0/1/0/0",
                              bus.out_valid, bus.in_ready, busy, bus.out_count); end
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    load_test1();
    send_prog();
    collect_resp(0, 1'b0);
    n_cmp++; if (obs_data !== 4'd6 || obs_count != 4 || obs_lat != 5)
      begin n_bad++; $display("FAIL midreset_rerun got data=%0d count=%0d lat=%0d want 6/4/5", obs_data, obs_count, obs_lat); end
  endtask

  task automatic test_upper_bit();
    prog_q.delete();
    add(0, 1, 2, 1, 1, 0);
    add(0, 0, 3, 0, 1, 0);
    add(0, 1, 0, 0, 0, 2);
    add(1, 4, 1, 0, 1, 0);
    send_prog();
    collect_resp(0, 1'b0);
    n_cmp++; if (obs_fault !== 1'b1 || obs_data !== '0 || obs_count != 4 || obs_lat != 1)
      begin n_bad++; $display("FAIL upper_bit got fault=%b data=%0d count=%0d lat=%0d want 1/0/4/1",
                              obs_fault, obs_data, obs_count, obs_lat); end
  endtask

  task automatic gen_random();
    int len;
    ins_t x;
    prog_q.delete();
    len = $urandom_range(1, NUM_PE);
    for (int k = 0; k < len; k++) begin
      x.op = 2'($urandom_range(0, 3));
      x.i0 = (k == 0) || ($urandom_range(0, 1) == 1);
      x.i1 = (k == 0) || ($urandom_range(0, 1) == 1);
      x.s0 = x.i0 ? DATA_W'($urandom_range(0, 15)) : DATA_W'($urandom_range(0, k - 1));
      x.s1 = x.i1 ? DATA_W'($urandom_range(0, 15)) : DATA_W'($urandom_range(0, k - 1));
      if ($urandom_range(0, 7) == 0) begin x.i0 = 1'b0; x.s0 = DATA_W'($urandom_range(k, 15)); end
      x.last = (k == len - 1) && (len < NUM_PE || $urandom_range(0, 1) == 1);
      prog_q.push_back(x);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ed; logic ef; int ec, el; logic early;
    for (int n = 0; n < 40; n++) begin
      gen_random();
      model(ed, ef, ec, el);
      exp_q.push_back(ed);
      early = ($urandom_range(0, 3) == 0);
      bus.out_ready = early;
      send_prog();
      collect_resp($urandom_range(0, 2), early);
      n_cmp++; if (obs_data !== exp_q.pop_front() || obs_fault !== ef || obs_count != ec)
        begin n_bad++; $display("FAIL rand%0d_resp got %0d/%b/%0d want %0d/%b/%0d", n, obs_data, obs_fault, obs_count, ed, ef, ec); end
      n_cmp++; if (obs_lat != el || obs_stable !== 1'b1 || obs_rdy_after !== 1'b1 || obs_valid_after !== 1'b0)
        begin n_bad++; $display("FAIL rand%0d_timing got lat=%0d stable=%b rdy=%b vld=%b want %0d/1/1/0",
                                n, obs_lat, obs_stable, obs_rdy_after, obs_valid_after, el); end
    end
  endtask

  task automatic test_wide();
    logic [20:0] p8[4];
    int g, lat;
    p8[0] = {1'b0, 8'd3, 8'd5, 1'b1, 1'b1, 2'b00};
    p8[1] = {1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 2'b01};
    p8[2] = {1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 2'b11};
    p8[3] = {1'b1, 8'd2, 8'd6, 1'b0, 1'b1, 2'b10};
    for (int k = 0; k < 4; k++) begin
      bus8.in_instr = p8[k];
      bus8.in_valid = 1'b1;
      g = 0;
      while (!bus8.in_ready && g < 50) begin @(negedge clock); g++; end
      @(posedge clock);
      @(negedge clock);
    end
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 200) begin @(negedge clock); lat++; end
    n_cmp++; if (bus8.out_data !== 8'd6 || bus8.out_fault !== 1'b0 || bus8.out_count !== 4'd4 || lat != 5)
      begin n_bad++; $display("FAIL wide_resp got data=%0d fault=%b count=%0d lat=%0d want 6/0/4/5",
                              bus8.out_data, bus8.out_fault, bus8.out_count, lat); end
    bus8.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_instr = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus8.in_instr = '0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    test_basic();
    test_wrap();
    test_self_ref();
    test_implicit_end_hold();
    test_reset_mid();
    test_upper_bit();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
